// File: rtl/sram_bank_ctrl_if.sv
// Bus bundle between the d/i OBI muxes (master side) and sram_bank_ctrl (slave side).
// The d port is read/write; the i port is read-only.
interface sram_bank_ctrl_if;
    logic        sram_d_req_i;
    logic        sram_d_gnt_o;
    logic [31:0] sram_d_addr_i;
    logic        sram_d_we_i;
    logic [3:0]  sram_d_be_i;
    logic [31:0] sram_d_wdata_i;
    logic        sram_d_rvalid_o;
    logic [31:0] sram_d_rdata_o;
    logic        sram_d_err_o;

    logic        sram_i_req_i;
    logic        sram_i_gnt_o;
    logic [31:0] sram_i_addr_i;
    logic        sram_i_rvalid_o;
    logic [31:0] sram_i_rdata_o;
    logic        sram_i_err_o;

    modport master (
        output sram_d_req_i, sram_d_addr_i, sram_d_we_i, sram_d_be_i, sram_d_wdata_i,
        output sram_i_req_i, sram_i_addr_i,
        input  sram_d_gnt_o, sram_d_rvalid_o, sram_d_rdata_o, sram_d_err_o,
        input  sram_i_gnt_o, sram_i_rvalid_o, sram_i_rdata_o, sram_i_err_o
    );

    modport slave (
        input  sram_d_req_i, sram_d_addr_i, sram_d_we_i, sram_d_be_i, sram_d_wdata_i,
        input  sram_i_req_i, sram_i_addr_i,
        output sram_d_gnt_o, sram_d_rvalid_o, sram_d_rdata_o, sram_d_err_o,
        output sram_i_gnt_o, sram_i_rvalid_o, sram_i_rdata_o, sram_i_err_o
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// Dual-port OBI front-end for an array of 512x32 SRAM banks with range-checked decode,
// error responses, first-illegal-address capture and d-write/i-read collision stalling.
// Optional macro SRAM_OUT_REG_EN adds an output register stage (response latency 2).
module sram_bank_ctrl #(
    parameter logic [31:0] SRAM_BASE_ADDR      = 32'h8000_0000,
    parameter int          SRAM_NUM_BLOCKS     = 24,
    parameter int          SRAM_LOG_BLOCK_SIZE = 9,
    parameter logic [31:0] SRAM_ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    sram_bank_ctrl_if.slave        bus,
    output logic                   illegal_memory_o,
    output logic [31:0]            illegal_addr_o,
    output logic                   illegal_vld_o,
    input  logic                   illegal_clr_i
);

    localparam int WORDS     = 1 << SRAM_LOG_BLOCK_SIZE;
    localparam int BLK_W     = (SRAM_NUM_BLOCKS > 1) ? $clog2(SRAM_NUM_BLOCKS) : 1;
    localparam int BLK_SHIFT = SRAM_LOG_BLOCK_SIZE + 2;

    typedef logic [BLK_W-1:0]               blk_t;
    typedef logic [SRAM_LOG_BLOCK_SIZE-1:0] word_t;

    logic [31:0] d_off, i_off, d_blk_full, i_blk_full;
    blk_t        d_blk, i_blk;
    word_t       d_word, i_word;
    logic        d_legal, i_legal, collide;
    logic        d_gnt, i_gnt, d_ill, i_ill;

    // Decode: the full-width block number is range-checked so non-power-of-two counts work.
    assign d_off      = bus.sram_d_addr_i - SRAM_BASE_ADDR;
    assign i_off      = bus.sram_i_addr_i - SRAM_BASE_ADDR;
    assign d_blk_full = d_off >> BLK_SHIFT;
    assign i_blk_full = i_off >> BLK_SHIFT;
    assign d_blk      = d_blk_full[BLK_W-1:0];
    assign i_blk      = i_blk_full[BLK_W-1:0];
    assign d_word     = bus.sram_d_addr_i[BLK_SHIFT-1:2];
    assign i_word     = bus.sram_i_addr_i[BLK_SHIFT-1:2];
    assign d_legal    = (bus.sram_d_addr_i >= SRAM_BASE_ADDR) && (d_blk_full < 32'(SRAM_NUM_BLOCKS));
    assign i_legal    = (bus.sram_i_addr_i >= SRAM_BASE_ADDR) && (i_blk_full < 32'(SRAM_NUM_BLOCKS));

    assign collide = bus.sram_d_req_i & bus.sram_d_we_i & d_legal & i_legal &
                     (d_blk == i_blk) & (d_word == i_word);

    assign d_gnt = bus.sram_d_req_i;
    assign i_gnt = bus.sram_i_req_i & ~collide;
    assign d_ill = d_gnt & ~d_legal;
    assign i_ill = i_gnt & ~i_legal;

    assign bus.sram_d_gnt_o = d_gnt;
    assign bus.sram_i_gnt_o = i_gnt;

    logic [31:0] bank_rd0 [SRAM_NUM_BLOCKS];
    logic [31:0] bank_rd1 [SRAM_NUM_BLOCKS];

    genvar gi;
    generate
        for (gi = 0; gi < SRAM_NUM_BLOCKS; gi++) begin : g_bank
            logic [31:0] mem [WORDS];
            logic [31:0] rd0_reg, rd1_reg;
            logic        cs0, cs1;

            assign cs0 = d_gnt & d_legal & (d_blk == blk_t'(gi));
            assign cs1 = i_gnt & i_legal & (i_blk == blk_t'(gi));

            // Port 0 read/write with byte mask, port 1 read-only; contents are not reset.
            always_ff @(posedge clk_i) begin
                if (cs0) begin
                    if (bus.sram_d_we_i) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.sram_d_be_i[b]) begin
                                mem[d_word][8*b +: 8] <= bus.sram_d_wdata_i[8*b +: 8];
                            end
                        end
                    end else begin
                        rd0_reg <= mem[d_word];
                    end
                end
                if (cs1) begin
                    rd1_reg <= mem[i_word];
                end
            end

            assign bank_rd0[gi] = rd0_reg;
            assign bank_rd1[gi] = rd1_reg;
        end
    endgenerate

    logic d_vld_reg, d_err_reg, d_we_reg, i_vld_reg, i_err_reg, ill_reg;
    blk_t d_blk_reg, i_blk_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_vld_reg <= 1'b0;
            d_err_reg <= 1'b0;
            d_we_reg  <= 1'b0;
            d_blk_reg <= '0;
            i_vld_reg <= 1'b0;
            i_err_reg <= 1'b0;
            i_blk_reg <= '0;
            ill_reg   <= 1'b0;
        end else begin
            d_vld_reg <= d_gnt;
            d_err_reg <= d_ill;
            d_we_reg  <= bus.sram_d_we_i;
            d_blk_reg <= d_blk;
            i_vld_reg <= i_gnt;
            i_err_reg <= i_ill;
            i_blk_reg <= i_blk;
            ill_reg   <= d_ill | i_ill;
        end
    end

    logic [31:0] d_rdata_next, i_rdata_next;

    // rdata stays 0 outside of a read response; write responses carry err only.
    always_comb begin
        d_rdata_next = '0;
        i_rdata_next = '0;
        if (d_vld_reg && !d_we_reg) begin
            d_rdata_next = d_err_reg ? SRAM_ERR_RDATA : bank_rd0[d_blk_reg];
        end
        if (i_vld_reg) begin
            i_rdata_next = i_err_reg ? SRAM_ERR_RDATA : bank_rd1[i_blk_reg];
        end
    end

    logic        ill_vld_reg;
    logic [31:0] ill_addr_reg;

    // A new illegal access beats a simultaneous clear; d wins when both ports are illegal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ill_vld_reg  <= 1'b0;
            ill_addr_reg <= '0;
        end else if ((d_ill | i_ill) && (!ill_vld_reg || illegal_clr_i)) begin
            ill_vld_reg  <= 1'b1;
            ill_addr_reg <= d_ill ? bus.sram_d_addr_i : bus.sram_i_addr_i;
        end else if (illegal_clr_i) begin
            ill_vld_reg  <= 1'b0;
        end
    end

    assign illegal_vld_o  = ill_vld_reg;
    assign illegal_addr_o = ill_addr_reg;

`ifdef SRAM_OUT_REG_EN
    logic        d_vld_out_reg, d_err_out_reg, i_vld_out_reg, i_err_out_reg, ill_out_reg;
    logic [31:0] d_rdata_out_reg, i_rdata_out_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_vld_out_reg   <= 1'b0;
            d_err_out_reg   <= 1'b0;
            d_rdata_out_reg <= '0;
            i_vld_out_reg   <= 1'b0;
            i_err_out_reg   <= 1'b0;
            i_rdata_out_reg <= '0;
            ill_out_reg     <= 1'b0;
        end else begin
            d_vld_out_reg   <= d_vld_reg;
            d_err_out_reg   <= d_err_reg;
            d_rdata_out_reg <= d_rdata_next;
            i_vld_out_reg   <= i_vld_reg;
            i_err_out_reg   <= i_err_reg;
            i_rdata_out_reg <= i_rdata_next;
            ill_out_reg     <= ill_reg;
        end
    end

    assign bus.sram_d_rvalid_o = d_vld_out_reg;
    assign bus.sram_d_err_o    = d_err_out_reg;
    assign bus.sram_d_rdata_o  = d_rdata_out_reg;
    assign bus.sram_i_rvalid_o = i_vld_out_reg;
    assign bus.sram_i_err_o    = i_err_out_reg;
    assign bus.sram_i_rdata_o  = i_rdata_out_reg;
    assign illegal_memory_o    = ill_out_reg;
`else
    assign bus.sram_d_rvalid_o = d_vld_reg;
    assign bus.sram_d_err_o    = d_err_reg;
    assign bus.sram_d_rdata_o  = d_rdata_next;
    assign bus.sram_i_rvalid_o = i_vld_reg;
    assign bus.sram_i_err_o    = i_err_reg;
    assign bus.sram_i_rdata_o  = i_rdata_next;
    assign illegal_memory_o    = ill_reg;
`endif

endmodule
